id_operand_bypass: RTL and testbench

Parametrised operand-resolution stage for the five-stage MIPS pipeline. It holds the IF/ID pipeline register and drives the register-file read addresses. It resolves every source operand through a prioritised forwarding network with NUM_FWD producer stages, raises the load-use interlock, and keeps resolved operands stable across multi-cycle ID stalls. The decoder consumes its outputs and produces id_to_ex_bus.

---
 rtl/id_operand_bypass_pkg.sv | 37 +++
 rtl/id_operand_bypass_operand_sel.sv | 70 +++++++
 rtl/id_operand_bypass.sv | 95 +++++++++
 tb/tb_id_operand_bypass.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/id_operand_bypass_pkg.sv
// Shared types and constants for the ID operand-resolution stage.
package id_operand_bypass_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned INST_W  = 32;

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int unsigned STALL_IF = 1;
  localparam int unsigned STALL_ID = 2;

  localparam int unsigned FWD_SRC_EX  = 0;
  localparam int unsigned FWD_SRC_MEM = 1;
  localparam int unsigned FWD_SRC_WB  = 2;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } if_id_t;

  // Register-specifier field read by a given operand port
  function automatic logic [4:0] src_field(input logic [INST_W-1:0] inst,
                                           input int unsigned port);
    case (port)
      0:       src_field = inst[25:21];
      1:       src_field = inst[20:16];
      default: src_field = inst[15:11];
    endcase
  endfunction

endpackage

// File: rtl/id_operand_bypass_operand_sel.sv
// Single-port operand resolution: register zero, youngest forward, hold, regfile.
module operand_sel #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_FWD = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REG_AW-1:0]           addr,
  input  logic [DATA_W-1:0]           rf_rdata,
  input  logic [NUM_FWD-1:0]          fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0]   fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
  input  logic [NUM_FWD-1:0]          fwd_is_load,
  input  logic                        rd_use,
  input  logic                        id_valid,
  input  logic                        hold_cap,
  input  logic                        hold_clr,
  output logic [DATA_W-1:0]           opnd_c,
  output logic [NUM_FWD-1:0]          hit_c,
  output logic                        load_stall_c
);

  logic              addr_nz;
  logic              match;
  logic              win_load;
  logic [DATA_W-1:0] win_data;
  logic              hold_vld;
  logic [DATA_W-1:0] hold_q;

  assign addr_nz = (addr != '0);

  // Priority pick of the youngest matching source; register zero never forwards
  always_comb begin
    match    = 1'b0;
    win_load = 1'b0;
    win_data = '0;
    hit_c    = '0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!match && addr_nz && fwd_we[i] &&
          (fwd_waddr[i*REG_AW +: REG_AW] == addr)) begin
        match    = 1'b1;
        win_load = fwd_is_load[i];
        win_data = fwd_wdata[i*DATA_W +: DATA_W];
        hit_c[i] = 1'b1;
      end
    end
  end

  // Operand mux and load-use detection
  always_comb begin
    opnd_c = rf_rdata;
    if (!addr_nz)      opnd_c = '0;
    else if (match)    opnd_c = win_data;
    else if (hold_vld) opnd_c = hold_q;
    load_stall_c = id_valid && rd_use && match && win_load;
  end

  // Hold register keeps forwarded data alive across ID stalls; loads are not captured
  always_ff @(posedge clk) begin
    if (rst || hold_clr) begin
      hold_vld <= 1'b0;
      hold_q   <= '0;
    end else if (hold_cap && addr_nz && (match ? !win_load : hold_vld)) begin
      hold_vld <= 1'b1;
      hold_q   <= opnd_c;
    end
  end

endmodule

// File: rtl/id_operand_bypass.sv
// IF/ID register plus per-port forwarding/hold network and load-use interlock.
module id_operand_bypass
  import id_operand_bypass_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_FWD = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  stall_bus_t                  stall,
  input  logic                        flush,
  input  logic                        if_valid,
  input  logic [PC_W-1:0]             if_pc,
  input  logic [INST_W-1:0]           if_inst,
  input  logic [NUM_RD-1:0]           rd_use,
  input  logic [NUM_FWD-1:0]          fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0]   fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
  input  logic [NUM_FWD-1:0]          fwd_is_load,
  output logic [NUM_RD*REG_AW-1:0]    rf_raddr,
  input  logic [NUM_RD*DATA_W-1:0]    rf_rdata,
  output logic                        id_valid,
  output logic [PC_W-1:0]             id_pc,
  output logic [INST_W-1:0]           id_inst,
  output logic [NUM_RD*DATA_W-1:0]    opnd,
  output logic [NUM_RD*NUM_FWD-1:0]   fwd_hit,
  output logic                        stallreq
);

  if_id_t            if_id_q;
  logic              id_stop;
  logic              if_stop;
  logic              hold_cap;
  logic              hold_clr;
  logic [NUM_RD-1:0] port_stall;
  logic              unused_stall;

  assign if_stop      = (stall[STALL_IF] == STOP);
  assign id_stop      = (stall[STALL_ID] == STOP);
  assign unused_stall = ^{stall[0], stall[STALL_W-1:STALL_ID+1]};

  // IF/ID register: reset/flush, bubble, load, else hold
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      if_id_q <= '0;
    end else if (if_stop && !id_stop) begin
      if_id_q <= '0;
    end else if (!if_stop) begin
      if_id_q.valid <= if_valid;
      if_id_q.pc    <= if_pc;
      if_id_q.inst  <= if_inst;
    end
  end

  assign id_valid = if_id_q.valid;
  assign id_pc    = if_id_q.pc;
  assign id_inst  = if_id_q.inst;

  assign hold_cap = id_stop && if_id_q.valid;
  assign hold_clr = !id_stop || flush;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [REG_AW-1:0] addr;

    assign addr = REG_AW'(src_field(if_id_q.inst, p));
    assign rf_raddr[p*REG_AW +: REG_AW] = addr;

    operand_sel #(
      .DATA_W  (DATA_W),
      .REG_AW  (REG_AW),
      .NUM_FWD (NUM_FWD)
    ) u_sel (
      .clk          (clk),
      .rst          (rst),
      .addr         (addr),
      .rf_rdata     (rf_rdata[p*DATA_W +: DATA_W]),
      .fwd_we       (fwd_we),
      .fwd_waddr    (fwd_waddr),
      .fwd_wdata    (fwd_wdata),
      .fwd_is_load  (fwd_is_load),
      .rd_use       (rd_use[p]),
      .id_valid     (if_id_q.valid),
      .hold_cap     (hold_cap),
      .hold_clr     (hold_clr),
      .opnd_c       (opnd[p*DATA_W +: DATA_W]),
      .hit_c        (fwd_hit[p*NUM_FWD +: NUM_FWD]),
      .load_stall_c (port_stall[p])
    );
  end

  assign stallreq = |port_stall;

endmodule

// File: tb/tb_id_operand_bypass.sv
// Directed bench for id_operand_bypass with hand-computed expectations.
module tb_id_operand_bypass;
  import id_operand_bypass_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NF = 3;

  logic              clk = 1'b0;
  logic              rst;
  stall_bus_t        stall;
  logic              flush;
  logic              if_valid;
  logic [31:0]       if_pc;
  logic [31:0]       if_inst;
  logic [NR-1:0]     rd_use;
  logic [NF-1:0]     fwd_we;
  logic [NF*AW-1:0]  fwd_waddr;
  logic [NF*DW-1:0]  fwd_wdata;
  logic [NF-1:0]     fwd_is_load;
  logic [NR*AW-1:0]  rf_raddr;
  logic [NR*DW-1:0]  rf_rdata;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_inst;
  logic [NR*DW-1:0]  opnd;
  logic [NR*NF-1:0]  fwd_hit;
  logic              stallreq;

  int n_tests = 0;
  int n_fail  = 0;

  id_operand_bypass #(.DATA_W(DW), .REG_AW(AW), .NUM_RD(NR), .NUM_FWD(NF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .rd_use(rd_use),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_is_load(fwd_is_load), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .opnd(opnd),
    .fwd_hit(fwd_hit), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
    mk_inst = {6'h00, rs, rt, 5'd0, 11'd0};
  endfunction

  task automatic set_fwd(input int i, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic ld);
    fwd_we[i]            = we;
    fwd_waddr[i*AW +: AW] = a;
    fwd_wdata[i*DW +: DW] = d;
    fwd_is_load[i]       = ld;
  endtask

  task automatic clr_fwd();
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_is_load = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0;
    if_valid = 1'b1; if_pc = 32'h100; if_inst = mk_inst(5'd8, 5'd9);
    rd_use = '0; rf_rdata = '0;
    clr_fwd();
    set_fwd(FWD_SRC_EX, 1'b1, 5'd0, 32'hFF, 1'b0);

    // Reset
    tick(); tick();
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_raddr", 32'(rf_raddr), 32'd0);
    chk("rst_opnd0", opnd[31:0], 32'd0);
    chk("rst_hit", 32'(fwd_hit), 32'd0);
    chk("rst_stallreq", 32'(stallreq), 32'd0);
    rst = 1'b0;
    tick();
    chk("load_valid", 32'(id_valid), 32'd1);
    chk("load_inst", id_inst, mk_inst(5'd8, 5'd9));
    chk("load_pc", id_pc, 32'h100);
    chk("load_raddr", 32'(rf_raddr), {22'd0, 5'd9, 5'd8});

    // Forwarding priority on rs=$8
    clr_fwd();
    set_fwd(FWD_SRC_EX, 1'b1, 5'd8, 32'h11, 1'b0);
    set_fwd(FWD_SRC_MEM, 1'b1, 5'd8, 32'h22, 1'b0);
    set_fwd(FWD_SRC_WB, 1'b1, 5'd8, 32'h33, 1'b0);
    rf_rdata = {32'h66, 32'h55};
    #1;
    chk("prio_ex", opnd[31:0], 32'h11);
    chk("prio_ex_hit", 32'(fwd_hit[2:0]), 32'b001);
    chk("prio_rt_rf", opnd[63:32], 32'h66);
    fwd_we[FWD_SRC_EX] = 1'b0; #1;
    chk("prio_mem", opnd[31:0], 32'h22);
    chk("prio_mem_hit", 32'(fwd_hit[2:0]), 32'b010);
    fwd_we[FWD_SRC_MEM] = 1'b0; #1;
    chk("prio_wb", opnd[31:0], 32'h33);
    chk("prio_wb_hit", 32'(fwd_hit[2:0]), 32'b100);
    fwd_we[FWD_SRC_WB] = 1'b0; #1;
    chk("prio_rf", opnd[31:0], 32'h55);
    chk("prio_rf_hit", 32'(fwd_hit), 32'd0);

    // Load-use on rt=$9
    clr_fwd();
    rd_use = 2'b10;
    set_fwd(FWD_SRC_EX, 1'b1, 5'd9, 32'hC0, 1'b1);
    set_fwd(FWD_SRC_MEM, 1'b1, 5'd9, 32'h77, 1'b0);
    #1;
    chk("lu_stall", 32'(stallreq), 32'd1);
    chk("lu_hit", 32'(fwd_hit[5:3]), 32'b001);
    rd_use = 2'b00; #1;
    chk("lu_nouse", 32'(stallreq), 32'd0);
    rd_use = 2'b10;
    set_fwd(FWD_SRC_EX, 1'b1, 5'd9, 32'h88, 1'b0);
    fwd_is_load[FWD_SRC_MEM] = 1'b1; #1;
    chk("lu_shadow_stall", 32'(stallreq), 32'd0);
    chk("lu_shadow_opnd", opnd[63:32], 32'h88);
    clr_fwd();
    rd_use = '0;

    // Stall hold: WB data seen once survives the stall
    if_inst = mk_inst(5'd4, 5'd0); if_pc = 32'h104; rf_rdata = '0;
    tick();
    stall = 6'b000110;
    set_fwd(FWD_SRC_WB, 1'b1, 5'd4, 32'hDEAD, 1'b0); #1;
    chk("hold_c1", opnd[31:0], 32'hDEAD);
    tick();
    clr_fwd(); #1;
    chk("hold_c2", opnd[31:0], 32'hDEAD);
    chk("hold_c2_hit", 32'(fwd_hit[2:0]), 32'd0);
    tick();
    chk("hold_c3", opnd[31:0], 32'hDEAD);
    set_fwd(FWD_SRC_MEM, 1'b1, 5'd4, 32'hBEEF, 1'b0); #1;
    chk("hold_override", opnd[31:0], 32'hBEEF);
    clr_fwd();
    stall = '0; if_inst = mk_inst(5'd4, 5'd0); if_pc = 32'h108;
    rf_rdata = {32'h0, 32'h1234};
    tick();
    chk("hold_release_pc", id_pc, 32'h108);
    chk("hold_release_opnd", opnd[31:0], 32'h1234);

    // Register zero never forwards, never interlocks
    if_inst = mk_inst(5'd0, 5'd4); if_pc = 32'h10C; rf_rdata = '0;
    tick();
    rd_use = 2'b01;
    set_fwd(FWD_SRC_EX, 1'b1, 5'd0, 32'hFFFF, 1'b1); #1;
    chk("zero_opnd", opnd[31:0], 32'd0);
    chk("zero_hit", 32'(fwd_hit[2:0]), 32'd0);
    chk("zero_stall", 32'(stallreq), 32'd0);
    clr_fwd(); rd_use = '0;

    // Flush while stalled clears IF/ID and hold registers
    stall = 6'b000110;
    set_fwd(FWD_SRC_WB, 1'b1, 5'd4, 32'hAAAA, 1'b0);
    tick();
    clr_fwd(); #1;
    chk("flush_pre_hold", opnd[63:32], 32'hAAAA);
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_inst", id_inst, 32'd0);
    chk("flush_raddr", 32'(rf_raddr), 32'd0);
    stall = 6'b000100; if_inst = mk_inst(5'd0, 5'd4); if_pc = 32'h110;
    rf_rdata = {32'h5151, 32'h0};
    tick();
    chk("flush_reload_valid", 32'(id_valid), 32'd1);
    chk("flush_hold_cleared", opnd[63:32], 32'h5151);

    // Reset mid-stall clears hold registers
    stall = 6'b000110; rf_rdata = '0;
    set_fwd(FWD_SRC_WB, 1'b1, 5'd4, 32'hCAFE, 1'b0);
    tick();
    clr_fwd(); #1;
    chk("rst_pre_hold", opnd[63:32], 32'hCAFE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 6'b000100; rf_rdata = {32'h7777, 32'h0};
    tick();
    chk("rst_hold_cleared", opnd[63:32], 32'h7777);

    // Bubble: IF stopped, ID advances
    stall = 6'b000010;
    tick();
    chk("bubble_valid", 32'(id_valid), 32'd0);
    chk("bubble_inst", id_inst, 32'd0);
    chk("bubble_pc", id_pc, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
